// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the BCD display formatter and the
// eight-digit seven-segment display stage it feeds.
package seven_seg_pkg;

    localparam int NUM_DIGITS  = 8;
    localparam int BCD_WIDTH   = 32;
    localparam int GUARD_WIDTH = 4;

    typedef logic [4:0] hex_digit_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FORMAT = 2'd2
    } fmt_state_t;

    localparam hex_digit_t DIGIT_BLANK = 5'h00;
    localparam hex_digit_t DIGIT_OVF   = 5'h1F;

    function automatic hex_digit_t make_digit(input logic en, input logic [3:0] nibble);
        return {en, nibble};
    endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction step for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3_nibble (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    // Conditional +3 correction
    always_comb begin
        if (nibble >= 4'd5) begin
            adjusted = nibble + 4'd3;
        end else begin
            adjusted = nibble;
        end
    end

endmodule

// File: rtl/bcd_display_formatter.sv
// Sequential binary-to-BCD converter (one bit per cycle) with leading-zero blanking
// and overflow marking; drives {enable, nibble} per digit to the display stage.
module bcd_display_formatter
    import seven_seg_pkg::*;
#(
    parameter int BIN_WIDTH     = 27,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Start,
    input  logic [BIN_WIDTH-1:0]           Value,
    output logic                           Busy,
    output logic                           Done,
    output logic                           Overflow,
    output logic [NUM_DIGITS-1:0][4:0]     hex_values
);

    localparam int CNT_W    = $clog2(BIN_WIDTH);
    localparam int BCD_FULL = BCD_WIDTH + GUARD_WIDTH;

    if (BIN_WIDTH < 4 || BIN_WIDTH > 27) begin : g_bad_width
        $error("bcd_display_formatter: BIN_WIDTH must be within 4..27");
    end

    fmt_state_t                      state_r;
    logic [BIN_WIDTH-1:0]            shift_r;
    logic [BCD_FULL-1:0]             bcd_r;
    logic [CNT_W-1:0]                count_r;
    logic [BCD_FULL-1:0]             bcd_adj_s;
    logic                            ovf_s;
    hex_digit_t [NUM_DIGITS-1:0]     fmt_digits_s;

    // The guard nibble never exceeds 1 for a 27-bit input, so it needs no correction.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .nibble   (bcd_r[4*g +: 4]),
            .adjusted (bcd_adj_s[4*g +: 4])
        );
    end
    assign bcd_adj_s[BCD_FULL-1:BCD_WIDTH] = bcd_r[BCD_FULL-1:BCD_WIDTH];

    // Digit enables from the finished BCD value; overflow replaces every digit
    always_comb begin
        logic seen;
        logic en;
        seen         = 1'b0;
        en           = 1'b0;
        ovf_s        = (bcd_r[BCD_FULL-1:BCD_WIDTH] != 4'h0);
        fmt_digits_s = {NUM_DIGITS{DIGIT_BLANK}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen = seen | (bcd_r[4*i +: 4] != 4'h0) | (i == 0);
            if (BLANK_LEADING) begin
                en = seen;
            end else begin
                en = 1'b1;
            end
            if (ovf_s) begin
                fmt_digits_s[i] = DIGIT_OVF;
            end else begin
                fmt_digits_s[i] = make_digit(en, bcd_r[4*i +: 4]);
            end
        end
    end

    // Control FSM, shift datapath and registered display outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= S_IDLE;
            shift_r    <= {BIN_WIDTH{1'b0}};
            bcd_r      <= {BCD_FULL{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Overflow   <= 1'b0;
            hex_values <= {NUM_DIGITS{DIGIT_BLANK}};
        end else begin
            Done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (Start) begin
                        shift_r <= Value;
                        bcd_r   <= {BCD_FULL{1'b0}};
                        count_r <= CNT_W'(BIN_WIDTH - 1);
                        Busy    <= 1'b1;
                        state_r <= S_SHIFT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    bcd_r   <= {bcd_adj_s[BCD_FULL-2:0], shift_r[BIN_WIDTH-1]};
                    shift_r <= {shift_r[BIN_WIDTH-2:0], 1'b0};
                    if (count_r == {CNT_W{1'b0}}) begin
                        state_r <= S_FORMAT;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                S_FORMAT: begin
                    hex_values <= fmt_digits_s;
                    Overflow   <= ovf_s;
                    Done       <= 1'b1;
                    Busy       <= 1'b0;
                    state_r    <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed self-checking bench for bcd_display_formatter (BIN_WIDTH=27, blanking on).
module tb_bcd_display_formatter;

    logic            Clock = 1'b0;
    logic            Reset;
    logic            Start;
    logic [26:0]     Value;
    logic            Busy;
    logic            Done;
    logic            Overflow;
    logic [7:0][4:0] hex_values;

    int n_vec = 0;
    int n_err = 0;

    bcd_display_formatter #(.BIN_WIDTH(27), .BLANK_LEADING(1'b1)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Value      (Value),
        .Busy       (Busy),
        .Done       (Done),
        .Overflow   (Overflow),
        .hex_values (hex_values)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_conv(input logic [26:0] v);
        Value = v;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!Done && cnt < 60);
        if (!Done) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done: no Done within %0d cycles", cnt);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Value = 27'd0;
        tick();
        tick();
        n_vec++;
        if ({Busy, Done, Overflow} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000", {Busy, Done, Overflow});
        end
        n_vec++;
        if (hex_values !== 40'h0) begin
            n_err++;
            $display("FAIL reset_hex: got %h expected %h", hex_values, 40'h0);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cnt;
        logic [39:0] exp;
        exp = {5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18};
        start_conv(27'd12345678);
        n_vec++;
        if (Busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got %b expected 1", Busy);
        end
        wait_done(cnt);
        n_vec++;
        if (cnt !== 28) begin
            n_err++;
            $display("FAIL basic_latency: got %0d expected 28 edges after accept", cnt);
        end
        n_vec++;
        if (hex_values !== exp) begin
            n_err++;
            $display("FAIL basic_hex: got %h expected %h", hex_values, exp);
        end
        n_vec++;
        if (Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ovf: got %b expected 0", Overflow);
        end
        tick();
        n_vec++;
        if ({Busy, Done} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_idle: got %b expected 00", {Busy, Done});
        end
    endtask

    task automatic test_blanking();
        int cnt;
        logic [39:0] exp;
        start_conv(27'd0);
        wait_done(cnt);
        exp = {{7{5'h00}}, 5'h10};
        n_vec++;
        if (hex_values !== exp) begin
            n_err++;
            $display("FAIL blank_zero: got %h expected %h", hex_values, exp);
        end
        start_conv(27'd1000);
        wait_done(cnt);
        exp = {{4{5'h00}}, 5'h11, 5'h10, 5'h10, 5'h10};
        n_vec++;
        if (hex_values !== exp) begin
            n_err++;
            $display("FAIL blank_1000: got %h expected %h", hex_values, exp);
        end
    endtask

    task automatic test_overflow();
        int cnt;
        logic [39:0] exp;
        start_conv(27'd99999999);
        wait_done(cnt);
        exp = {8{5'h19}};
        n_vec++;
        if (hex_values !== exp || Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_max: got %h/%b expected %h/0", hex_values, Overflow, exp);
        end
        start_conv(27'd100000000);
        wait_done(cnt);
        exp = {8{5'h1F}};
        n_vec++;
        if (hex_values !== exp || Overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_over: got %h/%b expected %h/1", hex_values, Overflow, exp);
        end
        start_conv(27'd5);
        tick();
        n_vec++;
        if (hex_values !== exp || Overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_hold: got %h/%b expected %h/1", hex_values, Overflow, exp);
        end
        wait_done(cnt);
        exp = {{7{5'h00}}, 5'h15};
        n_vec++;
        if (hex_values !== exp || Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %h/%b expected %h/0", hex_values, Overflow, exp);
        end
    endtask

    task automatic test_ignore_busy();
        int done_at;
        int done_cnt;
        int stale;
        logic [39:0] prev;
        logic [39:0] exp;
        prev     = {{7{5'h00}}, 5'h15};
        exp      = {5'h18, 5'h17, 5'h16, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11};
        done_at  = 0;
        done_cnt = 0;
        stale    = 0;
        start_conv(27'd87654321);
        for (int i = 1; i <= 40; i++) begin
            Start = (i == 3 || i == 10);
            Value = 27'd42;
            tick();
            Start = 1'b0;
            if (Done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end else if (done_at == 0 && hex_values !== prev) begin
                stale++;
            end
        end
        n_vec++;
        if (done_at !== 28 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL busy_ignore: got done_at=%0d count=%0d expected 28/1", done_at, done_cnt);
        end
        n_vec++;
        if (stale !== 0) begin
            n_err++;
            $display("FAIL busy_hold: got %0d changed cycles expected 0", stale);
        end
        n_vec++;
        if (hex_values !== exp) begin
            n_err++;
            $display("FAIL busy_result: got %h expected %h", hex_values, exp);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        logic [39:0] exp;
        start_conv(27'd12345678);
        wait_done(cnt);
        Value = 27'd99;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(cnt);
        exp = {{6{5'h00}}, 5'h19, 5'h19};
        n_vec++;
        if (cnt + 1 !== 29) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d expected 29 cycles between Dones", cnt + 1);
        end
        n_vec++;
        if (hex_values !== exp) begin
            n_err++;
            $display("FAIL b2b_hex: got %h expected %h", hex_values, exp);
        end
    endtask

    task automatic test_held_start();
        int c1;
        int c2;
        logic [39:0] exp;
        Value = 27'd1000;
        Start = 1'b1;
        wait_done(c1);
        wait_done(c2);
        Start = 1'b0;
        exp = {{4{5'h00}}, 5'h11, 5'h10, 5'h10, 5'h10};
        n_vec++;
        if (c1 !== 29 || c2 !== 29) begin
            n_err++;
            $display("FAIL held_period: got %0d/%0d expected 29/29", c1, c2);
        end
        n_vec++;
        if (hex_values !== exp) begin
            n_err++;
            $display("FAIL held_hex: got %h expected %h", hex_values, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int cnt;
        int dones;
        logic [39:0] exp;
        start_conv(27'd12345678);
        repeat (11) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_vec++;
        if ({Busy, Done, Overflow} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_flags: got %b expected 000", {Busy, Done, Overflow});
        end
        n_vec++;
        if (hex_values !== 40'h0) begin
            n_err++;
            $display("FAIL rstmid_hex: got %h expected %h", hex_values, 40'h0);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) dones++;
        end
        n_vec++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL rstmid_nodone: got %0d Done pulses expected 0", dones);
        end
        start_conv(27'd1000);
        wait_done(cnt);
        exp = {{4{5'h00}}, 5'h11, 5'h10, 5'h10, 5'h10};
        n_vec++;
        if (hex_values !== exp || cnt !== 28) begin
            n_err++;
            $display("FAIL rstmid_after: got %h lat %0d expected %h lat 28", hex_values, cnt, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_ignore_busy();
        test_back_to_back();
        test_held_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
